// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl
//
// Bit-serial sequencer for the right-to-left magnitude comparison network.
// Two WIDTH-bit operands are captured on a start handshake. One comparison
// cell is evaluated per clock, from bit 0 (LSB) up to bit WIDTH-1 (MSB), and
// a single registered carry p is threaded through the cells. The final carry
// is the result z, and a running equality flag gives eq. Both are presented
// together with a one-cycle done pulse.
//
// Carry semantics: p starts at incl.
//  - A cell where a<b forces p=1.
//  - A cell where a>b forces p=0.
//  - A cell with equal bits passes p through unchanged.
// The most significant differing bit therefore decides the result:
//  - incl=1 computes A<=B.
//  - incl=0 computes A<B.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request a comparison; only honoured in IDLE
//   incl     in   initial carry (1: A<=B, 0: A<B), sampled with start
//   a_in     in   [WIDTH-1:0] operand A, sampled with start
//   b_in     in   [WIDTH-1:0] operand B, sampled with start
//   abort    in   synchronous cancel of an operation in SHIFT
//   busy     out  high while bits are being processed
//   done     out  one-cycle pulse when z/eq become valid
//   z        out  comparison result, held until the next completed compare
//   eq       out  1 iff A==B, held until the next completed compare
//   bit_idx  out  [CNT_W-1:0] bit processed at the next edge, 0 outside SHIFT

module serial_cmp_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             incl,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             z,
    output logic             eq,
    output logic [CNT_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CNT_W-1:0] cnt;
    logic             p;
    logic             eqr;

    logic             a_bit;
    logic             b_bit;
    logic             p_next;
    logic             eqr_next;
    logic             last_bit;

    // Select the operand bits for the current cell.
    // An explicit compare-per-bit mux is used so that the counter (one bit
    // wider than a bit index needs to be) never indexes the operand words
    // directly.
    always_comb begin
        a_bit = 1'b0;
        b_bit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_bit = a_reg[i];
                b_bit = b_reg[i];
            end
        end
    end

    // One comparison cell plus the running equality term.
    // last_bit flags the MSB cell. cnt is never incremented past LAST_IDX,
    // so the terminal compare is safe even for WIDTH=1.
    always_comb begin
        p_next   = (~a_bit & b_bit) | (p & (~a_bit | b_bit));
        eqr_next = eqr & ~(a_bit ^ b_bit);
        last_bit = (cnt == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // Abort outranks the final bit, so an aborted operation never reaches
    // DONE. DONE always falls back to IDLE, which drops any start that
    // arrives while a result is being presented.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, carry/equality iteration and result registers.
    // Operands are only written in IDLE on start, so they stay stable for the
    // whole walk. z/eq are only written on the MSB cell: they hold the last
    // completed result across aborts and idle periods.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
            p     <= 1'b0;
            eqr   <= 1'b0;
            z     <= 1'b0;
            eq    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        p     <= incl;
                        eqr   <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        cnt <= '0;
                    end else begin
                        p   <= p_next;
                        eqr <= eqr_next;
                        if (last_bit) begin
                            cnt <= '0;
                            z   <= p_next;
                            eq  <= eqr_next;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs are decoded straight from the registered state.
    always_comb begin
        busy    = (state == SHIFT);
        done    = (state == DONE);
        bit_idx = (state == SHIFT) ? cnt : '0;
    end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb_serial_cmp_ctrl
//
// Self-checking bench for serial_cmp_ctrl. A WIDTH=8 instance and a WIDTH=1
// instance share the clock and reset. Expected z/eq pairs come from an
// arithmetic reference model. They are pushed to a scoreboard queue when a
// start is driven, and popped when the DUT raises done.

module tb_serial_cmp_ctrl;

    localparam int W   = 8;
    localparam int CW  = $clog2(W + 1);
    localparam int CW1 = $clog2(1 + 1);

    logic clk = 1'b0;
    logic rst_n;

    logic          start8, incl8, abort8;
    logic [W-1:0]  a8, b8;
    logic          busy8, done8, z8, eq8;
    logic [CW-1:0] bit_idx8;

    logic           start1, incl1, abort1;
    logic [0:0]     a1, b1;
    logic           busy1, done1, z1, eq1;
    logic [CW1-1:0] bit_idx1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [1:0] exp_q8[$];
    logic [1:0] exp_q1[$];

    // Free-running clock with a 10-time-unit period.
    always #5 clk = ~clk;

    serial_cmp_ctrl #(.WIDTH(W)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .incl    (incl8),
        .a_in    (a8),
        .b_in    (b8),
        .abort   (abort8),
        .busy    (busy8),
        .done    (done8),
        .z       (z8),
        .eq      (eq8),
        .bit_idx (bit_idx8)
    );

    serial_cmp_ctrl #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .incl    (incl1),
        .a_in    (a1),
        .b_in    (b1),
        .abort   (abort1),
        .busy    (busy1),
        .done    (done1),
        .z       (z1),
        .eq      (eq1),
        .bit_idx (bit_idx1)
    );

    // Reference model: plain magnitude comparison, returned as {z, eq}.
    function automatic logic [1:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic inc);
        logic zz;
        zz = inc ? (a <= b) : (a < b);
        return {zz, (a == b)};
    endfunction

    // Drive a one-cycle start on the 8-bit DUT.
    // On return, the start edge (edge 0) has just passed.
    task automatic start_op8(input logic [7:0] a, input logic [7:0] b,
                             input logic inc, input bit push);
        @(posedge clk);
        #1;
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        incl8  = inc;
        if (push) exp_q8.push_back(model(a, b, inc));
        @(posedge clk);
        #1;
        start8 = 1'b0;
    endtask

    // Follow one 8-bit operation from just after its start edge to the end.
    // Checks latency, the bit_idx sequence, the scoreboard result, the
    // one-cycle done pulse and that z/eq are held after done.
    task automatic wait_result8(input string name);
        int         busy_cnt;
        int         done_at;
        bit         idx_ok;
        logic [1:0] exp_v;
        logic [1:0] got;
        busy_cnt = 0;
        done_at  = 0;
        idx_ok   = 1'b1;
        exp_v    = 2'bxx;
        for (int i = 1; i <= 3 * W; i++) begin
            @(negedge clk);
            if (busy8) begin
                if (bit_idx8 !== CW'(busy_cnt)) idx_ok = 1'b0;
                busy_cnt++;
            end
            if (done8) begin
                done_at = i;
                break;
            end
        end
        n_checks++;
        if (done_at != W + 1 || busy_cnt != W)
            $display("[TB] FAIL %s latency: busy=%0d done_at=%0d, required busy=%0d done_at=%0d",
                     name, busy_cnt, done_at, W, W + 1);
        else n_pass++;
        n_checks++;
        if (!idx_ok) $display("[TB] FAIL %s bit_idx: sequence wrong, required 0..%0d", name, W - 1);
        else n_pass++;
        if (done_at != 0) begin
            n_checks++;
            if (exp_q8.size() == 0) begin
                $display("[TB] FAIL %s scoreboard: done with no expected entry", name);
            end else begin
                exp_v = exp_q8.pop_front();
                got   = {z8, eq8};
                if (got !== exp_v)
                    $display("[TB] FAIL %s result: z,eq=%b, required %b", name, got, exp_v);
                else n_pass++;
            end
            @(negedge clk);
            n_checks++;
            if (done8 !== 1'b0 || {z8, eq8} !== exp_v)
                $display("[TB] FAIL %s hold: done=%b z,eq=%b, required done=0 z,eq=%b",
                         name, done8, {z8, eq8}, exp_v);
            else n_pass++;
        end else if (exp_q8.size() != 0) begin
            void'(exp_q8.pop_front());
        end
    endtask

    task automatic run_cmp8(input logic [7:0] a, input logic [7:0] b,
                            input logic inc, input string name);
        start_op8(a, b, inc, 1'b1);
        wait_result8(name);
    endtask

    // Same flow as run_cmp8, but for the WIDTH=1 instance.
    task automatic run_cmp1(input logic a, input logic b, input logic inc,
                            input string name);
        int         busy_cnt;
        int         done_at;
        logic [1:0] exp_v;
        logic [1:0] got;
        busy_cnt = 0;
        done_at  = 0;
        @(posedge clk);
        #1;
        start1 = 1'b1;
        a1     = a;
        b1     = b;
        incl1  = inc;
        exp_q1.push_back(model({7'd0, a}, {7'd0, b}, inc));
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (busy1) busy_cnt++;
            if (done1) begin
                done_at = i;
                break;
            end
        end
        n_checks++;
        if (done_at != 2 || busy_cnt != 1)
            $display("[TB] FAIL %s latency: busy=%0d done_at=%0d, required busy=1 done_at=2",
                     name, busy_cnt, done_at);
        else n_pass++;
        n_checks++;
        if (exp_q1.size() == 0) begin
            $display("[TB] FAIL %s scoreboard: no expected entry", name);
        end else begin
            exp_v = exp_q1.pop_front();
            got   = {z1, eq1};
            if (done_at == 0 || got !== exp_v)
                $display("[TB] FAIL %s result: z,eq=%b done_at=%0d, required %b", name, got, done_at, exp_v);
            else n_pass++;
        end
    endtask

    // Reset values of both instances while rst_n is held low.
    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if ({busy8, done8, z8, eq8, bit_idx8} !== '0)
            $display("[TB] FAIL reset8: busy,done,z,eq,idx=%b, required all 0",
                     {busy8, done8, z8, eq8, bit_idx8});
        else n_pass++;
        n_checks++;
        if ({busy1, done1, z1, eq1, bit_idx1} !== '0)
            $display("[TB] FAIL reset1: busy,done,z,eq,idx=%b, required all 0",
                     {busy1, done1, z1, eq1, bit_idx1});
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed vectors (equal, MSB-decides, extremes) plus random operands.
    task automatic test_basic();
        logic [7:0] ra;
        logic [7:0] rb;
        run_cmp8(8'h35, 8'h35, 1'b1, "eq_incl");
        run_cmp8(8'h35, 8'h35, 1'b0, "eq_strict");
        run_cmp8(8'h80, 8'h7F, 1'b1, "msb_gt");
        run_cmp8(8'h01, 8'h02, 1'b0, "lsb_lt");
        run_cmp8(8'h00, 8'hFF, 1'b0, "zero_ff");
        run_cmp8(8'hFF, 8'h00, 1'b1, "ff_zero");
        run_cmp8(8'hFF, 8'hFF, 1'b0, "ff_ff");
        for (int k = 0; k < 4; k++) begin
            ra = 8'($urandom);
            rb = (k == 0) ? ra : 8'($urandom);
            run_cmp8(ra, rb, 1'($urandom), "random");
        end
    endtask

    // A second start with new operands while busy must be ignored.
    task automatic test_ignore_start();
        int n_done;
        n_done = 0;
        start_op8(8'h0F, 8'hF0, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        start8 = 1'b1;
        a8     = 8'hFF;
        b8     = 8'h00;
        incl8  = 1'b0;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done8) begin
                n_done++;
                n_checks++;
                if (exp_q8.size() == 0) begin
                    $display("[TB] FAIL ignore_start scoreboard: unexpected done");
                end else if ({z8, eq8} !== exp_q8[0]) begin
                    $display("[TB] FAIL ignore_start result: z,eq=%b, required %b", {z8, eq8}, exp_q8[0]);
                    void'(exp_q8.pop_front());
                end else begin
                    n_pass++;
                    void'(exp_q8.pop_front());
                end
            end
        end
        n_checks++;
        if (n_done != 1) $display("[TB] FAIL ignore_start done_count: got %0d, required 1", n_done);
        else n_pass++;
    endtask

    // Abort at bit 4: back to IDLE, no done, prior z/eq kept; then a normal run.
    task automatic test_abort();
        bit found;
        int n_done;
        bit held;
        found  = 1'b0;
        n_done = 0;
        held   = 1'b1;
        run_cmp8(8'h35, 8'h35, 1'b1, "abort_prior");
        start_op8(8'h80, 8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy8 && bit_idx8 == CW'(4)) begin
                found = 1'b1;
                break;
            end
        end
        abort8 = 1'b1;
        @(posedge clk);
        #1;
        abort8 = 1'b0;
        n_checks++;
        if (!found || {busy8, done8, bit_idx8} !== '0)
            $display("[TB] FAIL abort_idle: found=%0d busy,done,idx=%b, required found=1 all 0",
                     found, {busy8, done8, bit_idx8});
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) n_done++;
            if ({z8, eq8} !== 2'b11) held = 1'b0;
        end
        n_checks++;
        if (n_done != 0 || !held)
            $display("[TB] FAIL abort_hold: dones=%0d held=%0d, required dones=0 held=1", n_done, held);
        else n_pass++;
        run_cmp8(8'h01, 8'h02, 1'b0, "abort_after");
    endtask

    // Asynchronous reset mid-SHIFT, then a start on the first edge after release.
    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        start_op8(8'h12, 8'h34, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy8 && bit_idx8 == CW'(5)) begin
                found = 1'b1;
                break;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!found || {busy8, done8, z8, eq8, bit_idx8} !== '0)
            $display("[TB] FAIL async_reset: found=%0d busy,done,z,eq,idx=%b, required found=1 all 0",
                     found, {busy8, done8, z8, eq8, bit_idx8});
        else n_pass++;
        @(negedge clk);
        rst_n  = 1'b1;
        start8 = 1'b1;
        a8     = 8'hAA;
        b8     = 8'hAB;
        incl8  = 1'b0;
        exp_q8.push_back(model(8'hAA, 8'hAB, 1'b0));
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_result8("post_reset");
    endtask

    // start held high: the second operation starts WIDTH+2 cycles after the first.
    task automatic test_back_to_back();
        int n_done;
        int t_first;
        int t_second;
        n_done   = 0;
        t_first  = 0;
        t_second = 0;
        @(posedge clk);
        #1;
        start8 = 1'b1;
        a8     = 8'h10;
        b8     = 8'h20;
        incl8  = 1'b0;
        exp_q8.push_back(model(8'h10, 8'h20, 1'b0));
        @(posedge clk);
        #1;
        a8    = 8'hC3;
        b8    = 8'hC3;
        incl8 = 1'b1;
        exp_q8.push_back(model(8'hC3, 8'hC3, 1'b1));
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done8) begin
                n_done++;
                if (n_done == 1) t_first = i;
                else t_second = i;
                n_checks++;
                if (exp_q8.size() == 0) begin
                    $display("[TB] FAIL b2b scoreboard: unexpected done");
                end else if ({z8, eq8} !== exp_q8[0]) begin
                    $display("[TB] FAIL b2b result: z,eq=%b, required %b", {z8, eq8}, exp_q8[0]);
                    void'(exp_q8.pop_front());
                end else begin
                    n_pass++;
                    void'(exp_q8.pop_front());
                end
            end
            if (n_done == 1 && busy8) start8 = 1'b0;
            if (n_done == 2) break;
        end
        start8 = 1'b0;
        n_checks++;
        if (n_done != 2 || t_second - t_first != W + 2)
            $display("[TB] FAIL b2b spacing: dones=%0d gap=%0d, required dones=2 gap=%0d",
                     n_done, t_second - t_first, W + 2);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_width1();
        run_cmp1(1'b1, 1'b0, 1'b1, "w1_gt");
        run_cmp1(1'b1, 1'b1, 1'b1, "w1_eq_incl");
        run_cmp1(1'b0, 1'b1, 1'b0, "w1_lt");
        run_cmp1(1'b1, 1'b1, 1'b0, "w1_eq_strict");
    endtask

    // Main sequence: initialise, run every scenario, drain check, summary.
    initial begin
        start8 = 1'b0;
        incl8  = 1'b0;
        abort8 = 1'b0;
        a8     = '0;
        b8     = '0;
        start1 = 1'b0;
        incl1  = 1'b0;
        abort1 = 1'b0;
        a1     = '0;
        b1     = '0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_width1();
        n_checks++;
        if (exp_q8.size() != 0 || exp_q1.size() != 0)
            $display("[TB] FAIL scoreboard_drain: left %0d/%0d entries, required 0/0",
                     exp_q8.size(), exp_q1.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_cmp_ctrl.md
Name: serial_cmp_ctrl

Overview:
- Sequencing controller for the right-to-left iterative comparison network. Implemented as a bit-serial engine: one cell evaluation per clock.
- Captures two WIDTH-bit words on a start handshake and walks bit 0 (LSB) to bit WIDTH-1 (MSB), updating a single registered carry p.
- After the final (MSB) cell, presents the Z result plus an equality flag with a one-cycle done pulse.
- Replaces the unrolled combinational chain wherever area matters more than latency.

Parameters:
- WIDTH, 8: word width in bits (≥1). Also the number of SHIFT cycles.
- CNT_W, $clog2(WIDTH+1): bit-index counter width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a comparison; honoured only in IDLE
- incl  input  1  initial carry p0: 1 = compute A<=B, 0 = compute A<B; sampled with start
- a_in  input  WIDTH  operand A; sampled with start
- b_in  input  WIDTH  operand B; sampled with start
- abort  input  1  synchronous cancel of an operation in progress
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when z/eq become valid
- z  output  1  comparison result (A<=B or A<B, per incl)
- eq  output  1  1 iff A==B
- bit_idx  output  CNT_W  index of the bit processed at the next edge; 0 outside SHIFT

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, z=0, eq=0, bit_idx=0; operand registers and p cleared.
- FSM states:
  - IDLE
    - start=1 at an edge: load A/B shift registers, p<=incl, eqr<=1, cnt<=0, go to SHIFT.
    - start=0: stay in IDLE.
  - SHIFT (busy=1), at each edge with abort=0:
    - a=A[cnt], b=B[cnt].
    - p <= (~a & b) | (p & (~a | b)).
    - eqr <= eqr & ~(a ^ b).
    - cnt <= cnt+1.
    - If cnt==WIDTH-1: z<=next p, eq<=next eqr, go to DONE.
  - SHIFT with abort=1 at an edge: go to IDLE; z/eq keep their previous values; no done pulse. abort has priority over bit processing.
  - DONE: done=1 for exactly one cycle, then unconditionally return to IDLE. start is ignored in DONE.
- Latency: start sampled at edge 0; bits processed on edges 1..WIDTH; done high during the cycle following edge WIDTH. Back-to-back throughput is one result per WIDTH+2 cycles.
- start or operand changes while busy or in DONE are ignored; the captured operands stay stable.
- z and eq remain valid and held from the done cycle until the next completed comparison.
- abort in IDLE or DONE has no effect.
- WIDTH=1: exactly one SHIFT cycle; the counter terminal compare must not underflow.
- Counter never exceeds WIDTH-1 in SHIFT; bit_idx=cnt in SHIFT, 0 otherwise.
- Asynchronous reset mid-SHIFT: immediate return to the reset state; a start on the first edge after release is accepted normally.

Test Plan (WIDTH=8):
- A=0x35, B=0x35, incl=1, start pulse → busy for 8 cycles, done on cycle 9 after start; z=1, eq=1. Repeat with incl=0 → z=0, eq=1.
- A=0x80, B=0x7F, incl=1 → z=0, eq=0. A=0x01, B=0x02, incl=0 → z=1, eq=0. Confirms the MSB decision overrides lower bits.
- Start with A=0x0F, B=0xF0; raise start again with A=0xFF, B=0x00 at cycle 3 → second request ignored, single done, z=1.
- abort asserted at bit_idx=4 → IDLE next cycle, no done, z/eq keep the prior result; a new start completes normally.
- rst_n low at bit_idx=5 → all outputs 0 immediately (asynchronously). After release, start A=0xAA, B=0xAB, incl=0 → z=1.
- WIDTH=1 instance: A=1, B=0, incl=1 → done 2 cycles after start, z=0; A=B=1, incl=1 → z=1, eq=1.
